// File: rtl/demux_4ch_if.sv
// Handshake bundle for the 4-channel demux.
// Input side plus four consumer channels.
interface demux_4ch_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       select;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A, B, C, D;
  logic             A_valid, B_valid;
  logic             C_valid, D_valid;
  logic             A_ready, B_ready;
  logic             C_ready, D_ready;

  modport master (
    output select, in_data, in_valid,
    output A_ready, B_ready,
    output C_ready, D_ready,
    input  in_ready,
    input  A, B, C, D,
    input  A_valid, B_valid,
    input  C_valid, D_valid
  );

  modport slave (
    input  select, in_data, in_valid,
    input  A_ready, B_ready,
    input  C_ready, D_ready,
    output in_ready,
    output A, B, C, D,
    output A_valid, B_valid,
    output C_valid, D_valid
  );
endinterface

// File: rtl/demux_4ch.sv
// 4-channel demux with a small FIFO per channel.
// Define DEMUX_STATS_EN to enable per-channel pop counters.
module demux_4ch #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Enable,
  demux_4ch_if.slave  bus,
  output logic [31:0] count
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  logic [WIDTH-1:0] mem_q [4][DEPTH];
  ptr_t             wp_q [4];
  ptr_t             wp_d [4];
  ptr_t             rp_q [4];
  ptr_t             rp_d [4];
  logic [3:0]       rdy;
  logic [3:0]       full;
  logic [3:0]       empty;
  logic [3:0]       vld;
  logic [3:0]       push;
  logic [3:0]       pop;
  logic [WIDTH-1:0] dat [4];

  assign rdy = {bus.D_ready, bus.C_ready,
                bus.B_ready, bus.A_ready};

  // Occupancy, head word and pop per channel
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      empty[c] = (wp_q[c] == rp_q[c]);
      full[c]  = (wp_q[c][AW] != rp_q[c][AW]) &&
                 (wp_q[c][AW-1:0] == rp_q[c][AW-1:0]);
      vld[c]   = !empty[c] && !reset;
      pop[c]   = vld[c] && rdy[c];
      dat[c]   = vld[c] ?
                 mem_q[c][rp_q[c][AW-1:0]] : '0;
    end
  end

  assign bus.in_ready = Enable && !reset &&
                        !full[bus.select];

  // Push decode and next pointers
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      push[c] = bus.in_valid && bus.in_ready &&
                (bus.select == 2'(c));
      wp_d[c] = wp_q[c] + ptr_t'(push[c]);
      rp_d[c] = rp_q[c] + ptr_t'(pop[c]);
    end
  end

  // Pointer registers, cleared by reset
  always_ff @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (reset) begin
        wp_q[c] <= '0;
        rp_q[c] <= '0;
      end else begin
        wp_q[c] <= wp_d[c];
        rp_q[c] <= rp_d[c];
      end
    end
  end

  // Storage write; contents are don't-care when empty
  always_ff @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (push[c])
        mem_q[c][wp_q[c][AW-1:0]] <= bus.in_data;
    end
  end

  assign bus.A       = dat[0];
  assign bus.B       = dat[1];
  assign bus.C       = dat[2];
  assign bus.D       = dat[3];
  assign bus.A_valid = vld[0];
  assign bus.B_valid = vld[1];
  assign bus.C_valid = vld[2];
  assign bus.D_valid = vld[3];

`ifdef DEMUX_STATS_EN
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];

  // Delivered-word counters, wrap at 256
  always_comb begin
    for (int c = 0; c < 4; c++)
      cnt_d[c] = cnt_q[c] + 8'(pop[c]);
  end

  // Counter registers
  always_ff @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (reset) cnt_q[c] <= '0;
      else       cnt_q[c] <= cnt_d[c];
    end
  end

  assign count = reset ? '0 :
                 {cnt_q[3], cnt_q[2],
                  cnt_q[1], cnt_q[0]};
`else
  assign count = '0;
`endif
endmodule

// File: tb/tb_demux_4ch.sv
// Randomized and directed bench for demux_4ch
// against a queue-based reference model.
module tb_demux_4ch;
  localparam int W = 4;
  localparam int DEPTH = 2;

  logic        clk = 0;
  logic        reset;
  logic        Enable;
  logic [31:0] count;
  int          checks = 0;
  int          errors = 0;

  logic [W-1:0] mq [4][$];
  int           mcnt [4];

  demux_4ch_if #(.WIDTH(W)) bus ();

  demux_4ch #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .Enable (Enable),
    .bus    (bus),
    .count  (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_val(int c);
    case (c)
      0: obs_val = 32'(bus.A);
      1: obs_val = 32'(bus.B);
      2: obs_val = 32'(bus.C);
      default: obs_val = 32'(bus.D);
    endcase
  endfunction

  function automatic logic obs_vld(int c);
    case (c)
      0: obs_vld = bus.A_valid;
      1: obs_vld = bus.B_valid;
      2: obs_vld = bus.C_valid;
      default: obs_vld = bus.D_valid;
    endcase
  endfunction

  // One clock: drive at negedge, check, update model
  task automatic step(input bit rst, input bit en,
                      input logic [1:0] sel,
                      input logic [W-1:0] d,
                      input bit v,
                      input logic [3:0] rd);
    bit        eready;
    bit        epush;
    bit [3:0]  epop;
    bit        ev;
    logic [31:0] ed;
    logic [31:0] ecnt;
    string     nm;
    @(negedge clk);
    reset        = rst;
    Enable       = en;
    bus.select   = sel;
    bus.in_data  = d;
    bus.in_valid = v;
    bus.A_ready  = rd[0];
    bus.B_ready  = rd[1];
    bus.C_ready  = rd[2];
    bus.D_ready  = rd[3];
    #1;
    eready = en && !rst &&
             (mq[sel].size() < DEPTH);
    epush = v && eready;
    chk("in_ready", 32'(bus.in_ready), 32'(eready));
    for (int c = 0; c < 4; c++) begin
      nm = $sformatf("%c", 8'h41 + c);
      ev = !rst && (mq[c].size() > 0);
      ed = ev ? 32'(mq[c][0]) : 32'd0;
      epop[c] = ev && rd[c];
      chk({nm, "_valid"}, 32'(obs_vld(c)), 32'(ev));
      chk({nm, "_data"}, obs_val(c), ed);
    end
    ecnt = 0;
    if (!rst)
      for (int c = 0; c < 4; c++)
        ecnt[c*8 +: 8] = 8'(mcnt[c] % 256);
    chk("count", count, ecnt);
    @(posedge clk);
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        mq[c].delete();
        mcnt[c] = 0;
      end
    end else begin
      for (int c = 0; c < 4; c++)
        if (epop[c]) begin
          void'(mq[c].pop_front());
`ifdef DEMUX_STATS_EN
          mcnt[c] = mcnt[c] + 1;
`endif
        end
      if (epush) mq[sel].push_back(d);
    end
  endtask

  initial begin
    reset        = 1;
    Enable       = 0;
    bus.select   = 0;
    bus.in_data  = 0;
    bus.in_valid = 0;
    bus.A_ready  = 0;
    bus.B_ready  = 0;
    bus.C_ready  = 0;
    bus.D_ready  = 0;
    for (int c = 0; c < 4; c++) mcnt[c] = 0;

    step(1, 1, 0, 0, 1, 4'hf);
    step(1, 1, 0, 0, 0, 4'h0);

    step(0, 1, 2'b10, 4'h5, 1, 4'h0);
    #1;
    chk("r032_C", 32'(bus.C), 32'h5);
    chk("r032_C_valid", 32'(bus.C_valid), 1);
    chk("r032_A_valid", 32'(bus.A_valid), 0);
    chk("r032_D_valid", 32'(bus.D_valid), 0);
    step(0, 1, 0, 0, 0, 4'b0100);

    step(0, 1, 2'b01, 4'h1, 1, 4'h0);
    step(0, 1, 2'b01, 4'h2, 1, 4'h0);
    #1;
    chk("r033_full", 32'(bus.in_ready), 0);
    bus.select = 2'b00;
    #1;
    chk("r033_other", 32'(bus.in_ready), 1);
    step(0, 1, 2'b01, 4'h9, 1, 4'b0010);
    step(0, 1, 0, 0, 0, 4'b0010);
    step(0, 1, 0, 0, 0, 4'b0010);

    step(0, 1, 2'b11, 4'h3, 1, 4'h0);
    step(0, 1, 2'b11, 4'h4, 1, 4'h0);
    step(0, 1, 0, 0, 0, 4'b1000);
    step(0, 1, 0, 0, 0, 4'b1000);
    step(0, 1, 0, 0, 0, 4'b1000);

    step(0, 1, 2'b00, 4'h7, 1, 4'h0);
    step(0, 0, 2'b00, 4'h8, 1, 4'b0001);
    step(0, 0, 2'b00, 4'h8, 1, 4'b0001);

    step(0, 1, 2'b00, 4'ha, 1, 4'h0);
    step(0, 1, 2'b00, 4'hb, 1, 4'h0);
    step(1, 1, 2'b00, 4'hc, 0, 4'h0);
    #1;
    chk("r036_A_valid", 32'(bus.A_valid), 0);
    chk("r036_A", 32'(bus.A), 0);
    chk("r036_count", count, 0);
    step(0, 1, 2'b00, 4'h0, 0, 4'h0);

    for (int i = 0; i < 262; i++)
      step(0, 1, 2'b00, 4'(i), 1, 4'b0001);
    step(0, 1, 0, 0, 0, 4'b0001);
    step(0, 1, 0, 0, 0, 4'b0001);

    for (int i = 0; i < 2000; i++)
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) != 0),
           2'($urandom), 4'($urandom),
           1'($urandom), 4'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
